// File: rtl/cntry_req_gen_if.sv
// Signal-controller side bundle for the country-road request generator.
// Inputs: detector and light codes; outputs: request, queue count, error flag.
// No flow control; every signal is level-valued each cycle.
interface cntry_req_gen_if;
    logic       loop_raw;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       X;
    logic [3:0] car_count;
    logic       err;

    modport master (
        output loop_raw, hwy, cntry,
        input  X, car_count, err
    );

    modport slave (
        input  loop_raw, hwy, cntry,
        output X, car_count, err
    );
endinterface

// File: rtl/cntry_req_gen.sv
// Debounces the country loop detector, tracks queued vehicles and requests green.
// Latency: request rises 3+DEBOUNCE edges after loop_raw rises (7 at defaults).
// No backpressure: the controller samples X each cycle; nothing stalls this block.
module cntry_req_gen #(
    parameter int DEBOUNCE   = 4,
    parameter int DEPART_CYC = 2,
    parameter int MAX_GREEN  = 8
) (
    input  logic             clock,
    input  logic             clear,
    cntry_req_gen_if.slave   bus
);

    localparam logic [1:0] RED     = 2'd0;
    localparam logic [1:0] GREEN   = 2'd2;
    localparam logic [1:0] ILLEGAL = 2'd3;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [3:0] DEP_LAST = 4'(DEPART_CYC - 1);
    localparam logic [7:0] GRN_LAST = 8'(MAX_GREEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       s1, s2, filt;
    logic [3:0] deb_cnt;
    logic [3:0] dep_cnt;
    logic [7:0] grn_cnt;
    logic [3:0] car_count;
    logic       err;

    logic deb_done, arrive, depart, cntry_green, bad_lights;

    assign deb_done    = (deb_cnt == DEB_LAST);
    assign arrive      = ~filt & s2 & deb_done;
    assign cntry_green = (bus.cntry == GREEN);
    assign depart      = cntry_green & (dep_cnt == DEP_LAST);
    assign bad_lights  = ((bus.hwy != RED) && (bus.cntry != RED)) ||
                         (bus.hwy == ILLEGAL) || (bus.cntry == ILLEGAL);

    // Two-flop synchronizer followed by a run-length debounce filter.
    always_ff @(posedge clock) begin
        if (clear) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            filt    <= 1'b0;
            deb_cnt <= 4'd0;
        end else begin
            s1 <= bus.loop_raw;
            s2 <= s1;
            if (s2 != filt) begin
                if (deb_done) begin
                    filt    <= s2;
                    deb_cnt <= 4'd0;
                end else begin
                    deb_cnt <= deb_cnt + 4'd1;
                end
            end else begin
                deb_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear || !cntry_green || depart) begin
            dep_cnt <= 4'd0;
        end else begin
            dep_cnt <= dep_cnt + 4'd1;
        end
    end

    // Arrival and departure on the same edge cancel out.
    always_ff @(posedge clock) begin
        if (clear) begin
            car_count <= 4'd0;
        end else begin
            case ({arrive, depart})
                2'b10:   if (car_count != 4'd15) car_count <= car_count + 4'd1;
                2'b01:   if (car_count != 4'd0)  car_count <= car_count - 4'd1;
                default: car_count <= car_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            err <= 1'b0;
        end else begin
            err <= err | bad_lights;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            grn_cnt <= 8'd0;
        end else if (state == REQ) begin
            grn_cnt <= 8'd0;
        end else if (state == SERVE) begin
            grn_cnt <= grn_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (car_count != 4'd0) state_nxt = REQ;
            REQ:     if (cntry_green) state_nxt = SERVE;
            SERVE:   if ((car_count == 4'd0) || (grn_cnt == GRN_LAST) || !cntry_green)
                         state_nxt = HOLDOFF;
            HOLDOFF: if ((bus.hwy == GREEN) && (bus.cntry == RED)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.X         = (state == REQ) || (state == SERVE);
        bus.car_count = car_count;
        bus.err       = err;
    end

endmodule

// File: tb/tb_cntry_req_gen.sv
// Directed bench for cntry_req_gen at default parameters; expectations are queued
// at stimulus time and checked against the DUT after the stated number of edges.
module tb_cntry_req_gen;

    localparam logic [1:0] RED     = 2'd0;
    localparam logic [1:0] YELLOW  = 2'd1;
    localparam logic [1:0] GREEN   = 2'd2;
    localparam logic [1:0] ILLEGAL = 2'd3;

    typedef struct {
        string      tag;
        logic       x;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    cntry_req_gen_if bus ();

    cntry_req_gen dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Queue an expectation, advance n edges, then compare against the DUT.
    task automatic run(input int n, input string tag, input logic x,
                       input logic [3:0] cnt, input logic e);
        exp_t ex, got;
        ex.tag = tag; ex.x = x; ex.cnt = cnt; ex.err = e;
        sb.push_back(ex);
        step(n);
        got = sb.pop_front();
        checks++;
        assert (bus.X === got.x) else begin
            errors++;
            $error("FAIL %s.X observed=%b expected=%b", got.tag, bus.X, got.x);
        end
        checks++;
        assert (bus.car_count === got.cnt) else begin
            errors++;
            $error("FAIL %s.car_count observed=%0d expected=%0d", got.tag, bus.car_count, got.cnt);
        end
        checks++;
        assert (bus.err === got.err) else begin
            errors++;
            $error("FAIL %s.err observed=%b expected=%b", got.tag, bus.err, got.err);
        end
    endtask

    task automatic do_reset();
        clear        = 1'b1;
        bus.loop_raw = 1'b0;
        bus.hwy      = GREEN;
        bus.cntry    = RED;
        step(1);
        clear = 1'b0;
    endtask

    task automatic pulse();
        bus.loop_raw = 1'b1;
        step(8);
        bus.loop_raw = 1'b0;
        step(8);
    endtask

    initial begin
        bus.loop_raw = 1'b0;
        bus.hwy      = GREEN;
        bus.cntry    = RED;
        step(2);
        clear = 1'b0;
        run(0, "reset", 1'b0, 4'd0, 1'b0);

        // End-to-end latency from a held detector, then a single-vehicle service.
        bus.loop_raw = 1'b1;
        run(5, "pre_arrival", 1'b0, 4'd0, 1'b0);
        run(1, "arrival_edge6", 1'b0, 4'd1, 1'b0);
        run(1, "request_edge7", 1'b1, 4'd1, 1'b0);
        bus.loop_raw = 1'b0;
        bus.hwy      = RED;
        bus.cntry    = GREEN;
        run(1, "serve_entry", 1'b1, 4'd1, 1'b0);
        run(1, "first_depart", 1'b1, 4'd0, 1'b0);
        run(1, "empty_exit", 1'b0, 4'd0, 1'b0);
        bus.hwy   = GREEN;
        bus.cntry = RED;
        run(1, "holdoff_idle", 1'b0, 4'd0, 1'b0);

        // Three-sample glitch never passes the filter.
        do_reset();
        bus.loop_raw = 1'b1;
        step(3);
        bus.loop_raw = 1'b0;
        run(10, "glitch", 1'b0, 4'd0, 1'b0);

        // Three queued vehicles drain one per two green cycles.
        do_reset();
        repeat (3) pulse();
        run(0, "three_queued", 1'b1, 4'd3, 1'b0);
        bus.hwy   = RED;
        bus.cntry = GREEN;
        run(2, "drain_first", 1'b1, 4'd2, 1'b0);
        run(4, "drain_all", 1'b1, 4'd0, 1'b0);
        run(1, "drain_exit", 1'b0, 4'd0, 1'b0);
        bus.hwy   = GREEN;
        bus.cntry = RED;

        // Saturation at 15, then the green-time limit ends service.
        do_reset();
        repeat (16) pulse();
        run(0, "sat15", 1'b1, 4'd15, 1'b0);
        pulse();
        run(0, "sat15_again", 1'b1, 4'd15, 1'b0);
        bus.hwy   = RED;
        bus.cntry = GREEN;
        run(8, "max_green_hold", 1'b1, 4'd11, 1'b0);
        run(1, "max_green_exit", 1'b0, 4'd11, 1'b0);
        bus.hwy   = GREEN;
        bus.cntry = RED;

        // Country leaving green early ends service; holdoff then re-requests.
        do_reset();
        repeat (2) pulse();
        bus.hwy   = RED;
        bus.cntry = GREEN;
        run(1, "early_serve", 1'b1, 4'd2, 1'b0);
        bus.cntry = YELLOW;
        run(1, "early_exit", 1'b0, 4'd2, 1'b0);
        bus.hwy   = GREEN;
        bus.cntry = RED;
        run(1, "holdoff_to_idle", 1'b0, 4'd2, 1'b0);
        run(1, "rerequest", 1'b1, 4'd2, 1'b0);

        // Conflicting and illegal light codes set a sticky error.
        do_reset();
        bus.hwy   = YELLOW;
        bus.cntry = GREEN;
        run(1, "err_conflict", 1'b0, 4'd0, 1'b1);
        bus.hwy   = GREEN;
        bus.cntry = RED;
        run(5, "err_sticky", 1'b0, 4'd0, 1'b1);
        do_reset();
        run(0, "err_cleared", 1'b0, 4'd0, 1'b0);
        bus.hwy = ILLEGAL;
        run(1, "err_illegal", 1'b0, 4'd0, 1'b1);
        bus.hwy = GREEN;

        // Clear during service with five vehicles queued.
        do_reset();
        repeat (5) pulse();
        bus.hwy   = RED;
        bus.cntry = GREEN;
        run(1, "serve5", 1'b1, 4'd5, 1'b0);
        clear = 1'b1;
        run(1, "clear_in_serve", 1'b0, 4'd0, 1'b0);
        clear     = 1'b0;
        bus.hwy   = GREEN;
        bus.cntry = RED;
        run(3, "after_clear", 1'b0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
